exe_stage_mc: RTL and testbench

Parametrised, registered execute stage with operand forwarding and an iterative multiply/divide unit. It sits between the ID/EX and EX/MEM boundaries of the pipeline. It selects each ALU operand and the store data from the register value or the MEM/WB forwarding paths. Single-cycle ALU operations complete in one clock; unsigned multiply and divide run for WIDTH cycles, during which the stage stalls upstream.

---
 rtl/exe_stage_mc.sv | 210 +++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative unsigned MULU/DIVU.
// Latency: 1 cycle for ALU ops; MULU/DIVU complete WIDTH cycles after accept.
// Backpressure: stall_out is high while an iterative op runs; valid_in is ignored then.
module exe_stage_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clock2,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [3:0]       EXECUTE_command,
  input  logic [1:0]       input1_select,
  input  logic [1:0]       input2_select,
  input  logic [1:0]       store_select,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] store_input,
  input  logic [WIDTH-1:0] result_forwarding_MEMORY,
  input  logic [WIDTH-1:0] result_forwarding_WRITEBACK,
  output logic [WIDTH-1:0] result_ALU1,
  output logic [WIDTH-1:0] result_ALU2,
  output logic [WIDTH-1:0] store_output,
  output logic             valid_out,
  output logic             stall_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;       // running op is DIVU (else MULU)
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;         // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;         // multiplier+product low half / dividend+quotient
  logic [WIDTH-1:0] st_q, st_d;         // store data held until the iterative op completes
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic [WIDTH-1:0] sto_q, sto_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] opa, opb, st_mux, alu_res;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   mul_sum, r_sh;
  logic [WIDTH-1:0] diff;
  logic             ge, accept, long_op;
  logic [CW-1:0]    shamt;

  // Forwarding muxes for both operands and the store data.
  always_comb begin
    opa = input1;
    opb = input2;
    st_mux = store_input;
    case (input1_select)
      2'd1:    opa = result_forwarding_MEMORY;
      2'd2:    opa = result_forwarding_WRITEBACK;
      default: opa = input1;
    endcase
    case (input2_select)
      2'd1:    opb = result_forwarding_MEMORY;
      2'd2:    opb = result_forwarding_WRITEBACK;
      default: opb = input2;
    endcase
    case (store_select)
      2'd1:    st_mux = result_forwarding_MEMORY;
      2'd2:    st_mux = result_forwarding_WRITEBACK;
      default: st_mux = store_input;
    endcase
  end

  assign shamt   = opb[CW-1:0];
  assign accept  = valid_in & (state_q == IDLE) & ~flush;
  assign long_op = (EXECUTE_command == OP_MULU) | (EXECUTE_command == OP_DIVU);

  // Single-cycle ALU; opcodes 12-15 (and the iterative codes) pass operand 1.
  always_comb begin
    alu_res = opa;
    case (EXECUTE_command)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (opa < opb)};
      default: alu_res = opa;
    endcase
  end

  // One shift-add or restoring-subtract iteration on the running operands.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    r_sh    = {hi_q, lo_q[WIDTH-1]};
    ge      = (r_sh >= {1'b0, opnd_q});
    diff    = r_sh[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      step_hi = ge ? diff : r_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state: accept/launch in IDLE, iterate or abort in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    st_d    = st_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    sto_d   = sto_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (long_op) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = (EXECUTE_command == OP_DIVU);
            opnd_d  = (EXECUTE_command == OP_DIVU) ? opb : opa;
            lo_d    = (EXECUTE_command == OP_DIVU) ? opa : opb;
            hi_d    = '0;
            st_d    = st_mux;
          end else begin
            res1_d = alu_res;
            res2_d = '0;
            sto_d  = st_mux;
            vld_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            res1_d  = step_lo;
            res2_d  = step_hi;
            sto_d   = st_q;
            vld_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      st_q    <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      sto_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      st_q    <= st_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      sto_q   <= sto_d;
      vld_q   <= vld_d;
    end
  end

  assign result_ALU1  = res1_q;
  assign result_ALU2  = res2_q;
  assign store_output = sto_q;
  assign valid_out    = vld_q;
  assign stall_out    = (state_q == RUN);

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
  localparam int W = 32;

  logic         clock2 = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   EXECUTE_command = '0;
  logic [1:0]   input1_select = '0, input2_select = '0, store_select = '0;
  logic [W-1:0] input1 = '0, input2 = '0, store_input = '0;
  logic [W-1:0] result_forwarding_MEMORY = '0, result_forwarding_WRITEBACK = '0;
  logic [W-1:0] result_ALU1, result_ALU2, store_output;
  logic         valid_out, stall_out;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_r1, exp_r2, exp_st;

  exe_stage_mc #(.WIDTH(W)) dut (
    .clock2(clock2), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
    .EXECUTE_command(EXECUTE_command),
    .input1_select(input1_select), .input2_select(input2_select), .store_select(store_select),
    .input1(input1), .input2(input2), .store_input(store_input),
    .result_forwarding_MEMORY(result_forwarding_MEMORY),
    .result_forwarding_WRITEBACK(result_forwarding_WRITEBACK),
    .result_ALU1(result_ALU1), .result_ALU2(result_ALU2), .store_output(store_output),
    .valid_out(valid_out), .stall_out(stall_out)
  );

  always #5 clock2 = ~clock2;

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] r, m, w);
    if (s == 2'd1) return m;
    if (s == 2'd2) return w;
    return r;
  endfunction

  // Reference results from the operation definitions, using wide arithmetic.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, b,
                                 output logic [W-1:0] r1, output logic [W-1:0] r2);
    logic [2*W-1:0] p;
    int unsigned sh;
    logic [W-1:0] ones;
    ones = '1;
    sh = int'(b % W);
    r2 = '0;
    case (op)
      4'd0:  r1 = a + b;
      4'd1:  r1 = a - b;
      4'd2:  r1 = a & b;
      4'd3:  r1 = a | b;
      4'd4:  r1 = a ^ b;
      4'd5:  r1 = a << sh;
      4'd6:  r1 = a >> sh;
      4'd7:  r1 = (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0);
      4'd8:  r1 = ((a ^ {1'b1, {(W-1){1'b0}}}) < (b ^ {1'b1, {(W-1){1'b0}}})) ? 1 : 0;
      4'd9:  r1 = (a < b) ? 1 : 0;
      4'd10: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r1 = p[W-1:0];
        r2 = p[2*W-1:W];
      end
      4'd11: begin
        if (b == 0) begin r1 = ones; r2 = a; end
        else begin r1 = a / b; r2 = a % b; end
      end
      default: r1 = a;
    endcase
  endfunction

  task automatic set_op(input logic [3:0] op, input logic [W-1:0] a, b, st,
                        input logic [1:0] s1, s2, ss, input logic [W-1:0] mem, wb);
    EXECUTE_command = op;
    input1 = a; input2 = b; store_input = st;
    input1_select = s1; input2_select = s2; store_select = ss;
    result_forwarding_MEMORY = mem; result_forwarding_WRITEBACK = wb;
    valid_in = 1'b1;
    ref_op(op, pick(s1, a, mem, wb), pick(s2, b, mem, wb), exp_r1, exp_r2);
    exp_st = pick(ss, st, mem, wb);
  endtask

  // Launch an iterative op and wait (bounded) until stall_out drops; optionally
  // scramble all inputs and pulse valid_in while the op runs.
  task automatic run_long(input logic [3:0] op, input logic [W-1:0] a, b, st,
                          input logic [1:0] s1, s2, ss, input logic [W-1:0] mem, wb,
                          input bit pulse, output int cyc, output bit early);
    set_op(op, a, b, st, s1, s2, ss, mem, wb);
    @(negedge clock2);
    cyc = 0;
    early = 1'b0;
    while (stall_out === 1'b1 && cyc < 200) begin
      cyc++;
      if (valid_out !== 1'b0) early = 1'b1;
      valid_in = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pulse) begin
        EXECUTE_command = 4'($urandom_range(0, 15));
        input1 = $urandom; input2 = $urandom; store_input = $urandom;
        input1_select = 2'($urandom_range(0, 3));
        result_forwarding_MEMORY = $urandom; result_forwarding_WRITEBACK = $urandom;
      end
      @(negedge clock2);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    vectors++;
    if (result_ALU1 !== '0 || result_ALU2 !== '0 || store_output !== '0 ||
        valid_out !== 1'b0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got r1=%h r2=%h st=%h v=%b s=%b, want all 0",
               result_ALU1, result_ALU2, store_output, valid_out, stall_out);
    end
    @(negedge clock2);
    reset_n = 1'b1;
    @(negedge clock2);
    vectors++;
    if (valid_out !== 1'b0 || stall_out !== 1'b0 || result_ALU1 !== '0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got v=%b s=%b r1=%h, want 0 0 0",
               valid_out, stall_out, result_ALU1);
    end
  endtask

  task automatic test_add_fwd;
    set_op(4'd0, 32'd5, 32'd0, 32'h0000_1234, 2'd0, 2'd1, 2'd0, 32'hFFFF_FFFF, 32'd0);
    @(negedge clock2);
    valid_in = 1'b0;
    vectors++;
    if (result_ALU1 !== 32'd4 || result_ALU2 !== 32'd0 || valid_out !== 1'b1 ||
        store_output !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL add_fwd: got r1=%h r2=%h v=%b st=%h, want r1=4 r2=0 v=1 st=00001234",
               result_ALU1, result_ALU2, valid_out, store_output);
    end
    @(negedge clock2);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL add_valid_pulse: got v=%b, want 0", valid_out);
    end
  endtask

  task automatic test_fwd_sel;
    set_op(4'd1, 32'd0, 32'd3, 32'd0, 2'd2, 2'd3, 2'd1, 32'hA5A5_0001, 32'd10);
    @(negedge clock2);
    vectors++;
    if (result_ALU1 !== 32'd7 || store_output !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL sub_wb_sel3: got r1=%h st=%h, want r1=7 st=a5a50001",
               result_ALU1, store_output);
    end
    set_op(4'd7, 32'h8000_0000, 32'd33, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clock2);
    valid_in = 1'b0;
    vectors++;
    if (result_ALU1 !== 32'hC000_0000 || result_ALU2 !== 32'd0) begin
      miscompares++;
      $display("FAIL sra_shift33: got r1=%h r2=%h, want r1=c0000000 r2=0",
               result_ALU1, result_ALU2);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd10) op = op + 4'd2;
      set_op(op, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      @(negedge clock2);
      vectors++;
      if (result_ALU1 !== exp_r1 || result_ALU2 !== exp_r2 || store_output !== exp_st ||
          valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL alu_rand[%0d] op=%0d: got r1=%h r2=%h st=%h v=%b, want r1=%h r2=%h st=%h v=1",
                 i, op, result_ALU1, result_ALU2, store_output, valid_out, exp_r1, exp_r2, exp_st);
      end
    end
    valid_in = 1'b0;
    @(negedge clock2);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_valid_drop: got v=%b, want 0", valid_out);
    end
  endtask

  task automatic test_long(input string name, input logic [3:0] op, input logic [W-1:0] a, b,
                           input bit rand_sel);
    int cyc;
    bit early;
    logic [1:0] s1, s2, ss;
    s1 = rand_sel ? 2'($urandom_range(0, 3)) : 2'd0;
    s2 = rand_sel ? 2'($urandom_range(0, 3)) : 2'd0;
    ss = rand_sel ? 2'($urandom_range(0, 3)) : 2'd0;
    run_long(op, a, b, $urandom, s1, s2, ss, $urandom, $urandom, 1'b1, cyc, early);
    vectors++;
    if (cyc != W || early || valid_out !== 1'b1 || result_ALU1 !== exp_r1 ||
        result_ALU2 !== exp_r2 || store_output !== exp_st) begin
      miscompares++;
      $display("FAIL %s: got stall_cycles=%0d early_valid=%0b v=%b r1=%h r2=%h st=%h, want %0d 0 1 %h %h %h",
               name, cyc, early, valid_out, result_ALU1, result_ALU2, store_output,
               W, exp_r1, exp_r2, exp_st);
    end
  endtask

  task automatic test_mulu;
    test_long("mulu_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (result_ALU1 !== 32'h0000_0001 || result_ALU2 !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL mulu_max_const: got r1=%h r2=%h, want 00000001 fffffffe",
               result_ALU1, result_ALU2);
    end
    @(negedge clock2);
    vectors++;
    if (valid_out !== 1'b0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mulu_ignore_pulses: got v=%b s=%b, want 0 0", valid_out, stall_out);
    end
    for (int i = 0; i < 3; i++) test_long("mulu_rand", 4'd10, $urandom, $urandom, 1'b1);
  endtask

  task automatic test_divu;
    test_long("divu_100_7", 4'd11, 32'd100, 32'd7, 1'b0);
    vectors++;
    if (result_ALU1 !== 32'd14 || result_ALU2 !== 32'd2) begin
      miscompares++;
      $display("FAIL divu_100_7_const: got q=%h r=%h, want 0000000e 00000002", result_ALU1, result_ALU2);
    end
    test_long("divu_by_zero", 4'd11, 32'd55, 32'd0, 1'b0);
    vectors++;
    if (result_ALU1 !== 32'hFFFF_FFFF || result_ALU2 !== 32'd55) begin
      miscompares++;
      $display("FAIL divu_zero_const: got q=%h r=%h, want ffffffff 00000037", result_ALU1, result_ALU2);
    end
    for (int i = 0; i < 4; i++)
      test_long("divu_rand", 4'd11, $urandom, $urandom >> $urandom_range(0, 31), 1'b1);
  endtask

  task automatic test_flush;
    logic [W-1:0] h1, h2, hst;
    int bad;
    @(negedge clock2);
    h1 = exp_r1; h2 = exp_r2; hst = exp_st;
    set_op(4'd11, $urandom, $urandom | 32'd1, $urandom, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clock2);
    valid_in = 1'b0;
    repeat (9) @(negedge clock2);
    flush = 1'b1;
    @(negedge clock2);
    flush = 1'b0;
    vectors++;
    if (stall_out !== 1'b0 || valid_out !== 1'b0 || result_ALU1 !== h1 ||
        result_ALU2 !== h2 || store_output !== hst) begin
      miscompares++;
      $display("FAIL flush_run: got s=%b v=%b r1=%h r2=%h st=%h, want 0 0 %h %h %h",
               stall_out, valid_out, result_ALU1, result_ALU2, store_output, h1, h2, hst);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock2);
      if (valid_out !== 1'b0 || stall_out !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flush_quiet: got %0d cycles with valid/stall, want 0", bad);
    end
    set_op(4'd0, 32'd40, 32'd2, 32'd9, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clock2);
    h1 = exp_r1;
    set_op(4'd0, 32'd100, 32'd1, 32'd7, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    flush = 1'b1;
    @(negedge clock2);
    flush = 1'b0;
    valid_in = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || stall_out !== 1'b0 || result_ALU1 !== h1) begin
      miscompares++;
      $display("FAIL flush_with_valid: got v=%b s=%b r1=%h, want 0 0 %h",
               valid_out, stall_out, result_ALU1, h1);
    end
  endtask

  task automatic test_reset_mid_run;
    set_op(4'd11, 32'd1000, 32'd3, 32'd77, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clock2);
    valid_in = 1'b0;
    repeat (4) @(negedge clock2);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (result_ALU1 !== '0 || result_ALU2 !== '0 || store_output !== '0 ||
        valid_out !== 1'b0 || stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got r1=%h r2=%h st=%h v=%b s=%b, want all 0",
               result_ALU1, result_ALU2, store_output, valid_out, stall_out);
    end
    @(negedge clock2);
    reset_n = 1'b1;
    @(negedge clock2);
    vectors++;
    if (stall_out !== 1'b0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: got s=%b v=%b, want 0 0", stall_out, valid_out);
    end
    set_op(4'd0, 32'd20, 32'd22, 32'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clock2);
    valid_in = 1'b0;
    vectors++;
    if (result_ALU1 !== 32'd42 || valid_out !== 1'b1 || stall_out !== 1'b0 ||
        store_output !== 32'd5) begin
      miscompares++;
      $display("FAIL add_after_reset: got r1=%h v=%b s=%b st=%h, want 0000002a 1 0 00000005",
               result_ALU1, valid_out, stall_out, store_output);
    end
  endtask

  initial begin
    test_reset();
    test_add_fwd();
    test_fwd_sel();
    test_back_to_back();
    test_mulu();
    test_divu();
    test_flush();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end
endmodule
